seg7_to_binary_rx: RTL and testbench



---
 rtl/seg7_to_binary_rx_if.sv | 22 ++
 rtl/seg7_to_binary_rx.sv | 146 ++++++++++++++
 tb/tb_seg7_to_binary_rx.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/seg7_to_binary_rx_if.sv
// Segment-bus receive interface. The pattern source drives the segment and
// digit-select lines; the receiver returns decoded nibbles, bytes and errors.
interface seg7_to_binary_rx_if;
   logic [6:0] segment;
   logic       digit_sel;
   logic [3:0] nibble;
   logic       nibble_valid;
   logic       invalid;
   logic [7:0] byte_data;
   logic       byte_valid;
   logic [7:0] error_count;

   modport master (
      output segment, digit_sel,
      input  nibble, nibble_valid, invalid, byte_data, byte_valid, error_count
   );

   modport slave (
      input  segment, digit_sel,
      output nibble, nibble_valid, invalid, byte_data, byte_valid, error_count
   );
endinterface

// File: rtl/seg7_to_binary_rx.sv
// Seven-segment receiver: settles a sampled {digit select, pattern}, decodes
// it back to a hex nibble and pairs low/high digits into a byte.
//
// state     | meaning
// WAIT_LOW  | no partial byte held, waiting for a low-digit nibble
// WAIT_HIGH | low nibble stored, waiting for the high-digit nibble
module seg7_to_binary_rx #(
   parameter int STABLE_LIMIT = 4,
   parameter bit ACTIVE_LOW   = 1
) (
   input  logic i_Clk,
   input  logic i_Reset,
   seg7_to_binary_rx_if.slave bus
);

   localparam logic [7:0] LIMIT_M1 = 8'(STABLE_LIMIT - 1);
   localparam logic [7:0] LIMIT    = 8'(STABLE_LIMIT);

   typedef enum logic {WAIT_LOW, WAIT_HIGH} state_t;

   state_t     state, next_state;
   logic [6:0] pattern_norm;
   logic [7:0] sample_q, prev_q;
   logic [7:0] stable_cnt;
   logic       accepted_q;
   logic       same, accept;
   logic [3:0] dec_nibble;
   logic       dec_legal, dec_blank;
   logic       nib_ok, nib_bad;
   logic       store_low, emit_byte;
   logic [3:0] low_q;

   assign pattern_norm = ACTIVE_LOW ? ~bus.segment : bus.segment;
   assign same         = (sample_q == prev_q);
   // Accept on the clock that lifts the counter to the limit, only once per value.
   assign accept       = same && (stable_cnt == LIMIT_M1) && !accepted_q;
   assign nib_ok       = accept && dec_legal;
   assign nib_bad      = accept && !dec_legal && !dec_blank;

   // Input sample stage, previous-sample register and stability counter.
   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         sample_q   <= 8'h00;
         prev_q     <= 8'h00;
         stable_cnt <= 8'h00;
         accepted_q <= 1'b0;
      end else begin
         sample_q <= {bus.digit_sel, pattern_norm};
         prev_q   <= sample_q;
         if (!same) begin
            stable_cnt <= 8'h00;
            accepted_q <= 1'b0;
         end else begin
            if (stable_cnt != LIMIT) stable_cnt <= stable_cnt + 8'h01;
            if (accept) accepted_q <= 1'b1;
         end
      end
   end

   // Active-high glyph decode of the settled pattern.
   always_comb begin
      dec_nibble = 4'h0;
      dec_legal  = 1'b1;
      dec_blank  = 1'b0;
      case (sample_q[6:0])
         7'h7E: dec_nibble = 4'h0;
         7'h30: dec_nibble = 4'h1;
         7'h6D: dec_nibble = 4'h2;
         7'h79: dec_nibble = 4'h3;
         7'h33: dec_nibble = 4'h4;
         7'h5B: dec_nibble = 4'h5;
         7'h5F: dec_nibble = 4'h6;
         7'h70: dec_nibble = 4'h7;
         7'h7F: dec_nibble = 4'h8;
         7'h7B: dec_nibble = 4'h9;
         7'h77: dec_nibble = 4'hA;
         7'h1F: dec_nibble = 4'hB;
         7'h4E: dec_nibble = 4'hC;
         7'h3D: dec_nibble = 4'hD;
         7'h4F: dec_nibble = 4'hE;
         7'h47: dec_nibble = 4'hF;
         7'h00: begin
            dec_legal = 1'b0;
            dec_blank = 1'b1;
         end
         default: dec_legal = 1'b0;
      endcase
   end

   // Byte FSM state register.
   always_ff @(posedge i_Clk) begin
      if (i_Reset) state <= WAIT_LOW;
      else         state <= next_state;
   end

   // Byte FSM next state: pair a low digit with the following high digit.
   always_comb begin
      next_state = state;
      store_low  = 1'b0;
      emit_byte  = 1'b0;
      case (state)
         WAIT_LOW: begin
            if (nib_ok && !sample_q[7]) begin
               store_low  = 1'b1;
               next_state = WAIT_HIGH;
            end
         end
         WAIT_HIGH: begin
            if (nib_ok) begin
               if (!sample_q[7]) begin
                  store_low = 1'b1;
               end else begin
                  emit_byte  = 1'b1;
                  next_state = WAIT_LOW;
               end
            end else if (nib_bad) begin
               next_state = WAIT_LOW;
            end
         end
         default: next_state = WAIT_LOW;
      endcase
   end

   // Registered outputs, stored low digit and saturating error count.
   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         bus.nibble       <= 4'h0;
         bus.nibble_valid <= 1'b0;
         bus.invalid      <= 1'b0;
         bus.byte_data    <= 8'h00;
         bus.byte_valid   <= 1'b0;
         bus.error_count  <= 8'h00;
         low_q            <= 4'h0;
      end else begin
         bus.nibble_valid <= nib_ok;
         bus.invalid      <= nib_bad;
         bus.byte_valid   <= emit_byte;
         if (nib_ok)    bus.nibble    <= dec_nibble;
         if (store_low) low_q         <= dec_nibble;
         if (emit_byte) bus.byte_data <= {dec_nibble, low_q};
         if (nib_bad && (bus.error_count != 8'hFF))
            bus.error_count <= bus.error_count + 8'h01;
      end
   end

endmodule

// File: tb/tb_seg7_to_binary_rx.sv
// Directed bench for the seven-segment receiver (STABLE_LIMIT=4, active-low).
module tb_seg7_to_binary_rx;

   localparam int L = 4;

   logic i_Clk   = 1'b0;
   logic i_Reset = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cnt_nib, cnt_inv, cnt_byte, cnt_solo_byte;

   seg7_to_binary_rx_if bus ();

   seg7_to_binary_rx #(.STABLE_LIMIT(L), .ACTIVE_LOW(1'b1)) dut (
      .i_Clk   (i_Clk),
      .i_Reset (i_Reset),
      .bus     (bus)
   );

   always #5 i_Clk = ~i_Clk;

   // Advance one clock and sample outputs 1 ns after the edge.
   task automatic tick();
      @(posedge i_Clk);
      #1;
      if (bus.nibble_valid) cnt_nib++;
      if (bus.invalid) cnt_inv++;
      if (bus.byte_valid) cnt_byte++;
      if (bus.byte_valid && !bus.nibble_valid) cnt_solo_byte++;
   endtask

   task automatic clear_counts();
      cnt_nib = 0; cnt_inv = 0; cnt_byte = 0; cnt_solo_byte = 0;
   endtask

   task automatic hold(input logic [6:0] seg, input logic sel, input int n);
      bus.segment   = seg;
      bus.digit_sel = sel;
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic test_reset();
      bus.segment   = 7'h7F;
      bus.digit_sel = 1'b0;
      i_Reset = 1'b1;
      tick(); tick();
      i_Reset = 1'b0;
      n_tests++; if (bus.nibble !== 4'h0) begin n_fail++; $display("FAIL reset_nibble got %h want 0", bus.nibble); end
      n_tests++; if (bus.nibble_valid !== 1'b0) begin n_fail++; $display("FAIL reset_nv got %b want 0", bus.nibble_valid); end
      n_tests++; if (bus.invalid !== 1'b0) begin n_fail++; $display("FAIL reset_inv got %b want 0", bus.invalid); end
      n_tests++; if (bus.byte_data !== 8'h00) begin n_fail++; $display("FAIL reset_byte got %h want 00", bus.byte_data); end
      n_tests++; if (bus.byte_valid !== 1'b0) begin n_fail++; $display("FAIL reset_bv got %b want 0", bus.byte_valid); end
      n_tests++; if (bus.error_count !== 8'h00) begin n_fail++; $display("FAIL reset_err got %h want 00", bus.error_count); end
   endtask

   // Glyph 3 held: single pulse exactly L+2 samples after first presentation.
   task automatic test_latency();
      logic exp_nv;
      bus.segment   = 7'h06;
      bus.digit_sel = 1'b0;
      for (int j = 1; j <= L + 8; j++) begin
         tick();
         exp_nv = (j == L + 2);
         n_tests++;
         if (bus.nibble_valid !== exp_nv) begin
            n_fail++; $display("FAIL latency_nv tick %0d got %b want %b", j, bus.nibble_valid, exp_nv);
         end
         if (j == L + 2) begin
            n_tests++;
            if (bus.nibble !== 4'h3) begin n_fail++; $display("FAIL latency_nibble got %h want 3", bus.nibble); end
         end
      end
   endtask

   task automatic test_byte();
      clear_counts();
      hold(7'h24, 1'b0, 6);
      n_tests++; if (bus.nibble_valid !== 1'b1 || bus.nibble !== 4'h5) begin
         n_fail++; $display("FAIL byte_low got nv=%b nib=%h want nv=1 nib=5", bus.nibble_valid, bus.nibble); end
      hold(7'h08, 1'b1, 6);
      n_tests++; if (bus.byte_valid !== 1'b1 || bus.nibble_valid !== 1'b1) begin
         n_fail++; $display("FAIL byte_coincident got bv=%b nv=%b want 1 1", bus.byte_valid, bus.nibble_valid); end
      n_tests++; if (bus.byte_data !== 8'hA5) begin n_fail++; $display("FAIL byte_value got %h want A5", bus.byte_data); end
      n_tests++; if (cnt_nib !== 2 || cnt_byte !== 1 || cnt_solo_byte !== 0) begin
         n_fail++; $display("FAIL byte_counts got nib=%0d byte=%0d solo=%0d want 2 1 0", cnt_nib, cnt_byte, cnt_solo_byte); end
   endtask

   task automatic test_toggle();
      clear_counts();
      for (int i = 0; i < 10; i++) hold((i % 2 == 0) ? 7'h06 : 7'h24, 1'b0, 3);
      // Exactly L samples per value is still one short of acceptance.
      for (int i = 0; i < 6; i++) hold((i % 2 == 0) ? 7'h06 : 7'h24, 1'b0, L);
      n_tests++; if (cnt_nib !== 0 || cnt_inv !== 0 || cnt_byte !== 0) begin
         n_fail++; $display("FAIL toggle_pulses got nib=%0d inv=%0d byte=%0d want 0 0 0", cnt_nib, cnt_inv, cnt_byte); end
      n_tests++; if (bus.error_count !== 8'h00) begin n_fail++; $display("FAIL toggle_err got %h want 00", bus.error_count); end
   endtask

   task automatic test_invalid();
      hold(7'h24, 1'b0, 8);
      clear_counts();
      hold(7'h7F, 1'b0, 8);
      n_tests++; if (cnt_nib !== 0 || cnt_inv !== 0) begin
         n_fail++; $display("FAIL blank_pulses got nib=%0d inv=%0d want 0 0", cnt_nib, cnt_inv); end
      hold(7'h55, 1'b0, 8);
      n_tests++; if (cnt_inv !== 1) begin n_fail++; $display("FAIL invalid_pulse got %0d want 1", cnt_inv); end
      n_tests++; if (bus.error_count !== 8'h01) begin n_fail++; $display("FAIL invalid_err got %h want 01", bus.error_count); end
      n_tests++; if (bus.nibble !== 4'h5) begin n_fail++; $display("FAIL invalid_nibble_kept got %h want 5", bus.nibble); end
      clear_counts();
      hold(7'h08, 1'b1, 8);
      n_tests++; if (cnt_nib !== 1 || cnt_byte !== 0) begin
         n_fail++; $display("FAIL invalid_drop got nib=%0d byte=%0d want 1 0", cnt_nib, cnt_byte); end
      n_tests++; if (bus.nibble !== 4'hA) begin n_fail++; $display("FAIL invalid_next_nibble got %h want A", bus.nibble); end
   endtask

   task automatic test_saturate();
      clear_counts();
      for (int i = 0; i < 260; i++) begin
         hold(7'h55, 1'b0, 6);
         hold(7'h7F, 1'b0, 6);
         if (i == 9) begin
            n_tests++; if (bus.error_count !== 8'd11) begin n_fail++; $display("FAIL sat_mid got %0d want 11", bus.error_count); end
         end
      end
      n_tests++; if (cnt_inv !== 260) begin n_fail++; $display("FAIL sat_pulses got %0d want 260", cnt_inv); end
      n_tests++; if (bus.error_count !== 8'hFF) begin n_fail++; $display("FAIL sat_err got %h want FF", bus.error_count); end
   endtask

   task automatic test_reset_mid_byte();
      hold(7'h06, 1'b0, 8);
      i_Reset = 1'b1;
      tick();
      i_Reset = 1'b0;
      n_tests++; if (bus.nibble !== 4'h0 || bus.byte_data !== 8'h00 || bus.error_count !== 8'h00 ||
                     bus.nibble_valid !== 1'b0 || bus.invalid !== 1'b0 || bus.byte_valid !== 1'b0) begin
         n_fail++; $display("FAIL midreset_outputs got nib=%h byte=%h err=%h nv=%b inv=%b bv=%b want all 0",
                            bus.nibble, bus.byte_data, bus.error_count, bus.nibble_valid, bus.invalid, bus.byte_valid); end
      clear_counts();
      hold(7'h24, 1'b1, 8);
      n_tests++; if (bus.nibble !== 4'h5 || cnt_nib !== 1) begin
         n_fail++; $display("FAIL midreset_nibble got nib=%h count=%0d want 5 1", bus.nibble, cnt_nib); end
      n_tests++; if (cnt_byte !== 0) begin n_fail++; $display("FAIL midreset_no_byte got %0d want 0", cnt_byte); end
   endtask

   initial begin
      bus.segment   = 7'h7F;
      bus.digit_sel = 1'b0;
      clear_counts();
      test_reset();
      test_latency();
      test_byte();
      test_toggle();
      test_invalid();
      test_saturate();
      test_reset_mid_byte();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
